branch_resolution_queue: RTL and testbench

- Resolution-side partner of the two-level branch predictor.
- Records every prediction issued at fetch in an in-order FIFO of in-flight branches.
- When a branch resolves in execute, compares the actual outcome with the recorded prediction. Drives the predictor's update/update_value/pc-for-update, and raises a mispredict pulse so fetch can redirect and flush the wrong path.

---
 rtl/branch_resolution_queue.sv | 173 +++++++++++++++++
 tb/tb_branch_resolution_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_queue.sv
// In-order queue of in-flight predicted branches; on resolve, drives predictor update and mispredict.
// Optional BRQ_STATS_EN adds saturating branch_count / mispredict_count outputs.
module branch_resolution_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       push,
  input  logic [PC_WIDTH-1:0]        push_pc,
  input  logic                       push_prediction,
  input  logic                       resolve,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [PC_WIDTH-1:0]        head_pc,
  output logic                       update,
  output logic                       update_value,
  output logic [PC_WIDTH-1:0]        update_pc,
  output logic                       mispredict,
  output logic                       overflow,
`ifdef BRQ_STATS_EN
  output logic [15:0]                branch_count,
  output logic [15:0]                mispredict_count,
`endif
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PC_WIDTH-1:0] pc_mem_q [DEPTH];
  logic [DEPTH-1:0]    pred_mem_q;
  logic                wr_en;
  logic                update_q, update_d, update_value_q, update_value_d;
  logic [PC_WIDTH-1:0] update_pc_q, update_pc_d;
  logic                mispredict_q, mispredict_d;
  logic                overflow_q, overflow_d, underflow_q, underflow_d;
  logic                is_full, is_empty;
`ifdef BRQ_STATS_EN
  logic [15:0]         branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
`endif

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // NOTE: every variable gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    wr_en          = 1'b0;
    update_d       = 1'b0;
    update_value_d = 1'b0;
    update_pc_d    = '0;
    mispredict_d   = 1'b0;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
`ifdef BRQ_STATS_EN
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
`endif
    if (stall) begin
      // hold everything; pulses default to 0
    end else if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (resolve && is_empty) begin
      underflow_d = 1'b1;
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
    end else if (resolve) begin
      update_d       = 1'b1;
      update_value_d = resolve_taken;
      update_pc_d    = pc_mem_q[rd_ptr_q];
`ifdef BRQ_STATS_EN
      if (branch_count_q != 16'hFFFF) branch_count_d = branch_count_q + 16'd1;
`endif
      if (pred_mem_q[rd_ptr_q] == resolve_taken) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // Pop and push together keep count steady, so a push is legal even when full.
        if (push) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end else begin
        // Everything younger is wrong-path, including a same-cycle push.
        mispredict_d = 1'b1;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        count_d      = '0;
`ifdef BRQ_STATS_EN
        if (mispredict_count_q != 16'hFFFF) mispredict_count_d = mispredict_count_q + 16'd1;
`endif
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the entry storage is reset too, so head_pc/update_pc never expose stale X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pred_mem_q     <= '0;
      for (int i = 0; i < DEPTH; i++) pc_mem_q[i] <= '0;
      update_q       <= 1'b0;
      update_value_q <= 1'b0;
      update_pc_q    <= '0;
      mispredict_q   <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
`ifdef BRQ_STATS_EN
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      if (wr_en) begin
        pc_mem_q[wr_ptr_q]   <= push_pc;
        pred_mem_q[wr_ptr_q] <= push_prediction;
      end
      update_q       <= update_d;
      update_value_q <= update_value_d;
      update_pc_q    <= update_pc_d;
      mispredict_q   <= mispredict_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
`ifdef BRQ_STATS_EN
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
`endif
    end
  end

  assign full         = is_full;
  assign empty        = is_empty;
  assign count        = count_q;
  assign head_pc      = is_empty ? '0 : pc_mem_q[rd_ptr_q];
  assign update       = update_q;
  assign update_value = update_value_q;
  assign update_pc    = update_pc_q;
  assign mispredict   = mispredict_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
`ifdef BRQ_STATS_EN
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench for branch_resolution_queue (DEPTH=4, PC_WIDTH=16); covers BRQ_STATS_EN when defined.
module tb_branch_resolution_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, push, push_prediction, resolve, resolve_taken, flush;
  logic [15:0] push_pc;
  logic        full, empty, update, update_value, mispredict, overflow, underflow;
  logic [2:0]  count;
  logic [15:0] head_pc, update_pc;
`ifdef BRQ_STATS_EN
  logic [15:0] branch_count, mispredict_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolution_queue #(.DEPTH(4), .PC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .push(push), .push_pc(push_pc),
    .push_prediction(push_prediction), .resolve(resolve), .resolve_taken(resolve_taken),
    .flush(flush), .full(full), .empty(empty), .count(count), .head_pc(head_pc),
    .update(update), .update_value(update_value), .update_pc(update_pc),
    .mispredict(mispredict), .overflow(overflow),
`ifdef BRQ_STATS_EN
    .branch_count(branch_count), .mispredict_count(mispredict_count),
`endif
    .underflow(underflow)
  );

  // Apply one cycle of inputs, clock it in, return inputs to idle 1 ns after the edge.
  task automatic drive(input logic p, input logic [15:0] pc, input logic pred,
                       input logic r, input logic rt, input logic st, input logic fl);
    push = p; push_pc = pc; push_prediction = pred;
    resolve = r; resolve_taken = rt; stall = st; flush = fl;
    @(posedge clk); #1;
    push = 0; push_pc = '0; push_prediction = 0; resolve = 0; resolve_taken = 0; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; push = 0; push_pc = '0; push_prediction = 0;
    resolve = 0; resolve_taken = 0; stall = 0; flush = 0;
    @(posedge clk); #1;
    total++; if (count !== 3'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (update !== 1'b0 || mispredict !== 1'b0 || update_pc !== 16'h0)
      begin bad++; $display("FAIL reset_update got=%b/%b/%h exp=0/0/0", update, mispredict, update_pc); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin bad++; $display("FAIL reset_sticky got=%b/%b exp=0/0", overflow, underflow); end
    total++; if (head_pc !== 16'h0)  begin bad++; $display("FAIL reset_head got=%h exp=0", head_pc); end
    rst_n = 1;
  endtask

  task automatic test_push();
    drive(1, 16'h0010, 1, 0, 0, 0, 0);
    drive(1, 16'h0024, 0, 0, 0, 0, 0);
    drive(1, 16'h0038, 1, 0, 0, 0, 0);
    total++; if (count !== 3'd3)      begin bad++; $display("FAIL push_count got=%0d exp=3", count); end
    total++; if (head_pc !== 16'h0010) begin bad++; $display("FAIL push_head got=%h exp=0010", head_pc); end
    total++; if (empty !== 1'b0)      begin bad++; $display("FAIL push_empty got=%b exp=0", empty); end
  endtask

  task automatic test_resolve_correct();
    drive(0, 16'h0, 0, 1, 1, 0, 0);
    total++; if (update !== 1'b1 || update_value !== 1'b1 || update_pc !== 16'h0010)
      begin bad++; $display("FAIL correct_update got=%b/%b/%h exp=1/1/0010", update, update_value, update_pc); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL correct_mispredict got=%b exp=0", mispredict); end
    total++; if (count !== 3'd2 || head_pc !== 16'h0024)
      begin bad++; $display("FAIL correct_pop got=%0d/%h exp=2/0024", count, head_pc); end
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    total++; if (update !== 1'b0 || update_pc !== 16'h0)
      begin bad++; $display("FAIL update_pulse got=%b/%h exp=0/0", update, update_pc); end
  endtask

  task automatic test_mispredict();
    drive(1, 16'h0040, 0, 1, 1, 0, 0);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", mispredict); end
    total++; if (update !== 1'b1 || update_value !== 1'b1 || update_pc !== 16'h0024)
      begin bad++; $display("FAIL mis_update got=%b/%b/%h exp=1/1/0024", update, update_value, update_pc); end
    total++; if (count !== 3'd0 || empty !== 1'b1 || head_pc !== 16'h0)
      begin bad++; $display("FAIL mis_discard got=%0d/%b/%h exp=0/1/0", count, empty, head_pc); end
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got=%b exp=0", mispredict); end
  endtask

  task automatic test_overflow();
    drive(1, 16'h0100, 1, 0, 0, 0, 0);
    drive(1, 16'h0110, 1, 0, 0, 0, 0);
    drive(1, 16'h0120, 1, 0, 0, 0, 0);
    drive(1, 16'h0130, 1, 0, 0, 0, 0);
    total++; if (full !== 1'b1 || overflow !== 1'b0)
      begin bad++; $display("FAIL fill got=%b/%b exp=1/0", full, overflow); end
    drive(1, 16'h0050, 0, 0, 0, 0, 0);
    total++; if (full !== 1'b1 || overflow !== 1'b1 || count !== 3'd4)
      begin bad++; $display("FAIL overflow got=%b/%b/%0d exp=1/1/4", full, overflow, count); end
    drive(1, 16'h0140, 0, 1, 1, 0, 0);
    total++; if (count !== 3'd4 || update_pc !== 16'h0100 || head_pc !== 16'h0110 || mispredict !== 1'b0)
      begin bad++; $display("FAIL full_push_pop got=%0d/%h/%h/%b exp=4/0100/0110/0", count, update_pc, head_pc, mispredict); end
    drive(0, 16'h0, 0, 1, 1, 0, 0);
    drive(0, 16'h0, 0, 1, 1, 0, 0);
    drive(0, 16'h0, 0, 1, 1, 0, 0);
    total++; if (head_pc !== 16'h0140 || count !== 3'd1 || update_pc !== 16'h0130)
      begin bad++; $display("FAIL tail_order got=%h/%0d/%h exp=0140/1/0130", head_pc, count, update_pc); end
    drive(0, 16'h0, 0, 1, 0, 0, 0);
    total++; if (update !== 1'b1 || update_value !== 1'b0 || mispredict !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1)
      begin bad++; $display("FAIL not_taken_correct got=%b/%b/%b/%b/%b exp=1/0/0/1/1", update, update_value, mispredict, empty, overflow); end
  endtask

  task automatic test_underflow_stall_flush();
    drive(0, 16'h0, 0, 1, 1, 0, 0);
    total++; if (underflow !== 1'b1 || update !== 1'b0)
      begin bad++; $display("FAIL underflow got=%b/%b exp=1/0", underflow, update); end
    drive(1, 16'h0200, 1, 0, 0, 0, 0);
    drive(1, 16'h0210, 0, 0, 0, 0, 0);
    drive(1, 16'h0220, 1, 1, 0, 1, 0);
    total++; if (update !== 1'b0 || mispredict !== 1'b0 || count !== 3'd2 || head_pc !== 16'h0200)
      begin bad++; $display("FAIL stall got=%b/%b/%0d/%h exp=0/0/2/0200", update, mispredict, count, head_pc); end
    drive(1, 16'h0230, 1, 1, 1, 0, 1);
    total++; if (count !== 3'd0 || empty !== 1'b1 || update !== 1'b0)
      begin bad++; $display("FAIL flush got=%0d/%b/%b exp=0/1/0", count, empty, update); end
  endtask

  task automatic test_async_reset();
    drive(1, 16'h0300, 1, 0, 0, 0, 0);
    drive(1, 16'h0310, 1, 0, 0, 0, 0);
    drive(1, 16'h0320, 1, 0, 0, 0, 0);
    drive(1, 16'h0330, 1, 0, 0, 0, 0);
    drive(0, 16'h0, 0, 1, 1, 0, 0);
    total++; if (count !== 3'd3 || update !== 1'b1)
      begin bad++; $display("FAIL pre_reset got=%0d/%b exp=3/1", count, update); end
`ifdef BRQ_STATS_EN
    total++; if (branch_count !== 16'd8 || mispredict_count !== 16'd1)
      begin bad++; $display("FAIL stats got=%0d/%0d exp=8/1", branch_count, mispredict_count); end
`endif
    #2 rst_n = 0;
    #1;
    total++; if (count !== 3'd0 || update !== 1'b0 || empty !== 1'b1 || head_pc !== 16'h0)
      begin bad++; $display("FAIL async_reset got=%0d/%b/%b/%h exp=0/0/1/0", count, update, empty, head_pc); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin bad++; $display("FAIL async_sticky got=%b/%b exp=0/0", overflow, underflow); end
`ifdef BRQ_STATS_EN
    total++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0)
      begin bad++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
`endif
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_push();
    test_resolve_correct();
    test_mispredict();
    test_overflow();
    test_underflow_stall_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
